// File: rtl/mem_writer_if.sv
// Command, stream and memory-write signals of mem_writer, bundled as one interface.
// checksum_o is present only when MEMW_CHECKSUM_EN is defined.
interface mem_writer_if #(
  parameter int WIDTH      = 16,
  parameter int ADDR_WIDTH = 6
);
  logic                  start_i;
  logic                  mode_i;
  logic [ADDR_WIDTH-1:0] start_addr_i;
  logic [ADDR_WIDTH:0]   len_i;
  logic [WIDTH-1:0]      fill_i;
  logic                  abort_i;
  logic                  wvalid_i;
  logic [WIDTH-1:0]      wdata_i;
  logic                  wready_o;
  logic                  mem_we_o;
  logic [ADDR_WIDTH-1:0] mem_addr_o;
  logic [WIDTH-1:0]      mem_wdata_o;
  logic                  busy_o;
  logic                  done_o;
  logic [ADDR_WIDTH:0]   count_o;
`ifdef MEMW_CHECKSUM_EN
  logic [WIDTH-1:0]      checksum_o;
`endif

  modport master (
    output start_i, mode_i, start_addr_i, len_i, fill_i, abort_i, wvalid_i, wdata_i,
    input  wready_o, mem_we_o, mem_addr_o, mem_wdata_o, busy_o, done_o, count_o
`ifdef MEMW_CHECKSUM_EN
    , input checksum_o
`endif
  );

  modport slave (
    input  start_i, mode_i, start_addr_i, len_i, fill_i, abort_i, wvalid_i, wdata_i,
    output wready_o, mem_we_o, mem_addr_o, mem_wdata_o, busy_o, done_o, count_o
`ifdef MEMW_CHECKSUM_EN
    , output checksum_o
`endif
  );
endinterface

// File: rtl/mem_writer.sv
// Write-side engine for a DEPTH x WIDTH single-port memory: stream load or constant fill.
// Define MEMW_CHECKSUM_EN to add checksum_o (sum mod 2^WIDTH of words written this operation).
module mem_writer #(
  parameter int SIZE       = 1024,
  parameter int WIDTH      = 16,
  parameter int DEPTH      = SIZE / WIDTH,
  parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
  input logic         clk_i,
  input logic         rst_i,
  mem_writer_if.slave bus
);
  typedef enum logic [1:0] {IDLE, LOAD, FILL, DONE} state_t;

  localparam logic [ADDR_WIDTH:0]   DEPTH_CNT = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

  state_t                state, state_nxt;
  logic [ADDR_WIDTH-1:0] addr;
  logic [ADDR_WIDTH:0]   remaining;
  logic [ADDR_WIDTH:0]   count;
  logic [ADDR_WIDTH:0]   len_clamp;
  logic [WIDTH-1:0]      fill;
  logic [WIDTH-1:0]      wr_word;
  logic                  take_start;
  logic                  write_fire;
  logic                  last_word;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [WIDTH-1:0]      mem_wdata;
  logic                  wready;
  logic                  busy;
  logic                  done;

  assign len_clamp  = (bus.len_i > DEPTH_CNT) ? DEPTH_CNT : bus.len_i;
  assign take_start = (state == IDLE) && bus.start_i;
  assign last_word  = (remaining == (ADDR_WIDTH+1)'(1));
  // abort suppresses the write that would otherwise be registered on the same edge
  assign write_fire = !bus.abort_i && (((state == LOAD) && bus.wvalid_i) || (state == FILL));
  assign wr_word    = (state == FILL) ? fill : bus.wdata_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (bus.start_i) begin
              if (bus.len_i == '0) state_nxt = DONE;
              else                 state_nxt = bus.mode_i ? FILL : LOAD;
            end
      LOAD: if (bus.abort_i || (bus.wvalid_i && last_word)) state_nxt = DONE;
      FILL: if (bus.abort_i || last_word) state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    wready = 1'b0;
    busy   = 1'b1;
    done   = 1'b0;
    case (state)
      IDLE:    busy   = 1'b0;
      LOAD:    wready = 1'b1;
      DONE:    done   = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      addr      <= '0;
      remaining <= '0;
      count     <= '0;
      fill      <= '0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      mem_we <= write_fire;
      if (take_start) begin
        addr      <= bus.start_addr_i;
        remaining <= len_clamp;
        count     <= '0;
        fill      <= bus.fill_i;
      end else if (write_fire) begin
        mem_addr  <= addr;
        mem_wdata <= wr_word;
        addr      <= (addr == LAST_ADDR) ? '0 : addr + 1'b1;
        remaining <= remaining - 1'b1;
        count     <= count + 1'b1;
      end
    end
  end

`ifdef MEMW_CHECKSUM_EN
  logic [WIDTH-1:0] checksum;

  always_ff @(posedge clk_i) begin
    if (rst_i)           checksum <= '0;
    else if (take_start) checksum <= '0;
    else if (write_fire) checksum <= checksum + wr_word;
  end

  assign bus.checksum_o = checksum;
`endif

  assign bus.wready_o    = wready;
  assign bus.busy_o      = busy;
  assign bus.done_o      = done;
  assign bus.mem_we_o    = mem_we;
  assign bus.mem_addr_o  = mem_addr;
  assign bus.mem_wdata_o = mem_wdata;
  assign bus.count_o     = count;
endmodule

// File: tb/tb_mem_writer.sv
// Bench for mem_writer: randomized stream/fill operations against a list-of-writes reference model.
`timescale 1ns/1ps
module tb_mem_writer;
  localparam int W = 16, AW = 6, DEPTH = 64;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_writer_if #(.WIDTH(W), .ADDR_WIDTH(AW)) bus();
  mem_writer #(.SIZE(1024), .WIDTH(W)) dut (.clk_i(clk), .rst_i(rst), .bus(bus));

  int ntests = 0, nfail = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [AW-1:0] wa_q[$];
  logic [W-1:0]  wd_q[$];
  int            wc_q[$];
  int            dn_c_q[$];
  logic [AW:0]   dn_n_q[$];
  logic [W-1:0]  dn_s_q[$];
  int            hs_q[$];
  logic [AW-1:0] exp_a_q[$];
  logic [W-1:0]  exp_d_q[$];
  logic [W-1:0]  exp_sum;
  logic [W-1:0]  words[DEPTH];
  logic [W-1:0]  mem_dut[DEPTH];
  logic [W-1:0]  mem_ref[DEPTH];

  // observe outputs half a cycle after the active edge
  always @(negedge clk) begin
    if (bus.mem_we_o === 1'b1) begin
      wa_q.push_back(bus.mem_addr_o);
      wd_q.push_back(bus.mem_wdata_o);
      wc_q.push_back(cyc);
      mem_dut[bus.mem_addr_o] = bus.mem_wdata_o;
    end
    if (bus.done_o === 1'b1) begin
      dn_c_q.push_back(cyc);
      dn_n_q.push_back(bus.count_o);
`ifdef MEMW_CHECKSUM_EN
      dn_s_q.push_back(bus.checksum_o);
`else
      dn_s_q.push_back('0);
`endif
    end
  end

  task automatic clear_logs;
    wa_q.delete(); wd_q.delete(); wc_q.delete();
    dn_c_q.delete(); dn_n_q.delete(); dn_s_q.delete();
    exp_a_q.delete(); exp_d_q.delete();
  endtask

  // Reference: an operation writes min(len,DEPTH) words (fewer if aborted) to consecutive addresses mod DEPTH
  task automatic model(input bit mode, input logic [AW-1:0] a, input logic [AW:0] l,
                       input logic [W-1:0] f, input int abort_at);
    int n;
    n = (int'(l) > DEPTH) ? DEPTH : int'(l);
    if (abort_at >= 0 && abort_at < n) n = abort_at;
    exp_sum = '0;
    for (int j = 0; j < n; j++) begin
      exp_a_q.push_back(AW'((int'(a) + j) % DEPTH));
      exp_d_q.push_back(mode ? f : words[j]);
      exp_sum = exp_sum + (mode ? f : words[j]);
      mem_ref[(int'(a) + j) % DEPTH] = mode ? f : words[j];
    end
  endtask

  task automatic do_op(input bit mode, input logic [AW-1:0] a, input logic [AW:0] l,
                       input logic [W-1:0] f, input int vpct, input int abort_at,
                       input int poke_at, input int rst_at, output int t0);
    int i, n;
    bit v, finished;
    n = (int'(l) > DEPTH) ? DEPTH : int'(l);
    hs_q.delete();
    i = 0;
    finished = 1'b0;
    @(negedge clk);
    t0 = cyc;
    bus.start_i = 1'b1; bus.mode_i = mode; bus.start_addr_i = a; bus.len_i = l; bus.fill_i = f;
    @(negedge clk);
    bus.start_i = 1'b0;
    for (int c = 0; c < 300; c++) begin
      if (!bus.busy_o) begin finished = 1'b1; break; end
      bus.abort_i = (abort_at >= 0 && cyc == t0 + 1 + abort_at);
      rst = (rst_at >= 0 && cyc == t0 + 1 + rst_at);
      if (poke_at >= 0 && cyc == t0 + 1 + poke_at) begin
        bus.start_i = 1'b1; bus.mode_i = ~mode; bus.start_addr_i = AW'(a + 7);
        bus.len_i = 7'd2; bus.fill_i = ~f;
      end else begin
        bus.start_i = 1'b0;
      end
      if (vpct < 0) v = (c % 2 == 0);
      else          v = ($urandom_range(99) < vpct);
      v = v && (i < n);
      bus.wvalid_i = v;
      bus.wdata_i  = words[(i < DEPTH) ? i : 0];
      if (v && bus.wready_o && !bus.abort_i && !rst) begin hs_q.push_back(cyc); i++; end
      @(negedge clk);
    end
    bus.wvalid_i = 1'b0; bus.abort_i = 1'b0; bus.start_i = 1'b0; rst = 1'b0;
    ntests++;
    if (!finished) begin nfail++; $display("FAIL op_timeout: busy=%0b required 0", bus.busy_o); end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    ntests++;
    if ({bus.mem_we_o, bus.mem_addr_o, bus.mem_wdata_o, bus.busy_o, bus.done_o, bus.count_o, bus.wready_o} !== '0) begin
      nfail++;
      $display("FAIL reset_outputs: we=%0b addr=%0d data=%h busy=%0b done=%0b count=%0d wready=%0b required all 0",
               bus.mem_we_o, bus.mem_addr_o, bus.mem_wdata_o, bus.busy_o, bus.done_o, bus.count_o, bus.wready_o);
    end
`ifdef MEMW_CHECKSUM_EN
    ntests++;
    if (bus.checksum_o !== '0) begin nfail++; $display("FAIL reset_checksum: got %h required 0", bus.checksum_o); end
`endif
    rst = 1'b0;
    @(negedge clk);
    ntests++;
    if ({bus.busy_o, bus.done_o, bus.mem_we_o} !== 3'b000) begin
      nfail++; $display("FAIL reset_idle: busy/done/we=%b required 000", {bus.busy_o, bus.done_o, bus.mem_we_o});
    end
  endtask

  task automatic test_stream;
    int t0;
    foreach (words[j]) words[j] = 16'h1111 * W'(j + 1);
    clear_logs();
    model(1'b0, 6'd0, 7'd4, 16'h0, -1);
    do_op(1'b0, 6'd0, 7'd4, 16'h0, 100, -1, -1, -1, t0);
    ntests++;
    if (wa_q.size() != 4) begin nfail++; $display("FAIL stream_nwrites: got %0d required 4", wa_q.size()); end
    for (int j = 0; j < 4 && j < wa_q.size(); j++) begin
      ntests++;
      if ({wa_q[j], wd_q[j], wc_q[j]} !== {exp_a_q[j], exp_d_q[j], t0 + 2 + j}) begin
        nfail++;
        $display("FAIL stream_write%0d: addr=%0d data=%h cyc=%0d required addr=%0d data=%h cyc=%0d",
                 j, wa_q[j], wd_q[j], wc_q[j], exp_a_q[j], exp_d_q[j], t0 + 2 + j);
      end
    end
    ntests++;
    if (dn_c_q.size() != 1 || dn_c_q[0] != t0 + 5 || dn_n_q[0] !== 7'd4) begin
      nfail++; $display("FAIL stream_done: pulses=%0d cyc=%0d count=%0d required 1 pulse at %0d count 4",
                        dn_c_q.size(), (dn_c_q.size() > 0) ? dn_c_q[0] : -1, (dn_n_q.size() > 0) ? dn_n_q[0] : 0, t0 + 5);
    end
  endtask

  task automatic test_backpressure;
    int t0;
    foreach (words[j]) words[j] = W'($urandom);
    clear_logs();
    model(1'b0, 6'd5, 7'd3, 16'h0, -1);
    do_op(1'b0, 6'd5, 7'd3, 16'h0, -1, -1, -1, -1, t0);
    ntests++;
    if (wa_q.size() != 3 || hs_q.size() != 3) begin
      nfail++; $display("FAIL bp_nwrites: writes=%0d handshakes=%0d required 3", wa_q.size(), hs_q.size());
    end
    for (int j = 0; j < wa_q.size() && j < hs_q.size() && j < 3; j++) begin
      ntests++;
      if ({wa_q[j], wd_q[j], wc_q[j]} !== {exp_a_q[j], exp_d_q[j], hs_q[j] + 1}) begin
        nfail++;
        $display("FAIL bp_write%0d: addr=%0d data=%h cyc=%0d required addr=%0d data=%h cyc=%0d",
                 j, wa_q[j], wd_q[j], wc_q[j], exp_a_q[j], exp_d_q[j], hs_q[j] + 1);
      end
    end
    ntests++;
    if (dn_c_q.size() != 1 || wc_q.size() == 0 || dn_c_q[0] != wc_q[wc_q.size()-1] || dn_n_q[0] !== 7'd3) begin
      nfail++; $display("FAIL bp_done: pulses=%0d count=%0d required 1 pulse with last write, count 3",
                        dn_c_q.size(), (dn_n_q.size() > 0) ? dn_n_q[0] : 0);
    end
  endtask

  task automatic test_fill_wrap;
    int t0;
    clear_logs();
    model(1'b1, 6'd62, 7'd4, 16'hA5A5, -1);
    do_op(1'b1, 6'd62, 7'd4, 16'hA5A5, 0, -1, -1, -1, t0);
    ntests++;
    if (wa_q.size() != 4) begin nfail++; $display("FAIL wrap_nwrites: got %0d required 4", wa_q.size()); end
    for (int j = 0; j < 4 && j < wa_q.size(); j++) begin
      ntests++;
      if ({wa_q[j], wd_q[j], wc_q[j]} !== {exp_a_q[j], exp_d_q[j], t0 + 2 + j}) begin
        nfail++;
        $display("FAIL wrap_write%0d: addr=%0d data=%h cyc=%0d required addr=%0d data=%h cyc=%0d",
                 j, wa_q[j], wd_q[j], wc_q[j], exp_a_q[j], exp_d_q[j], t0 + 2 + j);
      end
    end
    ntests++;
    if (dn_c_q.size() != 1 || dn_c_q[0] != t0 + 5 || dn_n_q[0] !== 7'd4) begin
      nfail++; $display("FAIL wrap_done: pulses=%0d required 1 at cyc %0d count 4", dn_c_q.size(), t0 + 5);
    end
  endtask

  task automatic test_zero_clamp;
    int t0;
    logic [AW-1:0] a;
    clear_logs();
    do_op(1'b0, 6'd9, 7'd0, 16'h0, 100, -1, -1, -1, t0);
    ntests++;
    if (wa_q.size() != 0 || dn_c_q.size() != 1 || dn_c_q[0] != t0 + 1 || dn_n_q[0] !== 7'd0) begin
      nfail++; $display("FAIL zero_len: writes=%0d pulses=%0d done_cyc=%0d required 0 writes, 1 pulse at %0d",
                        wa_q.size(), dn_c_q.size(), (dn_c_q.size() > 0) ? dn_c_q[0] : -1, t0 + 1);
    end
    clear_logs();
    a = AW'($urandom);
    model(1'b1, a, 7'd65, 16'h3C5A, -1);
    do_op(1'b1, a, 7'd65, 16'h3C5A, 0, -1, -1, -1, t0);
    ntests++;
    if (wa_q.size() != 64) begin nfail++; $display("FAIL clamp_nwrites: got %0d required 64", wa_q.size()); end
    for (int j = 0; j < 64 && j < wa_q.size(); j++) begin
      ntests++;
      if ({wa_q[j], wd_q[j]} !== {exp_a_q[j], exp_d_q[j]}) begin
        nfail++; $display("FAIL clamp_write%0d: addr=%0d data=%h required addr=%0d data=%h",
                          j, wa_q[j], wd_q[j], exp_a_q[j], exp_d_q[j]);
      end
    end
    ntests++;
    if (dn_c_q.size() != 1 || dn_c_q[0] != t0 + 65 || dn_n_q[0] !== 7'd64) begin
      nfail++; $display("FAIL clamp_done: pulses=%0d count=%0d required 1 pulse at %0d count 64",
                        dn_c_q.size(), (dn_n_q.size() > 0) ? dn_n_q[0] : 0, t0 + 65);
    end
  endtask

  task automatic test_abort_reset;
    int t0;
    clear_logs();
    model(1'b1, 6'd10, 7'd8, 16'h1234, 2);
    do_op(1'b1, 6'd10, 7'd8, 16'h1234, 0, 2, -1, -1, t0);
    ntests++;
    if (wa_q.size() != 2 || dn_c_q.size() != 1 || dn_c_q[0] != t0 + 4 || dn_n_q[0] !== 7'd2) begin
      nfail++; $display("FAIL abort: writes=%0d pulses=%0d count=%0d required 2 writes, 1 pulse at %0d, count 2",
                        wa_q.size(), dn_c_q.size(), (dn_n_q.size() > 0) ? dn_n_q[0] : 0, t0 + 4);
    end
    clear_logs();
    model(1'b1, 6'd20, 7'd6, 16'h0F0F, -1);
    do_op(1'b1, 6'd20, 7'd6, 16'h0F0F, 0, -1, 2, -1, t0);
    ntests++;
    if (wa_q.size() != 6 || dn_c_q.size() != 1 || dn_n_q[0] !== 7'd6) begin
      nfail++; $display("FAIL start_busy: writes=%0d pulses=%0d required 6 writes, 1 pulse", wa_q.size(), dn_c_q.size());
    end
    for (int j = 0; j < 6 && j < wa_q.size(); j++) begin
      ntests++;
      if ({wa_q[j], wd_q[j]} !== {exp_a_q[j], exp_d_q[j]}) begin
        nfail++; $display("FAIL start_busy_write%0d: addr=%0d data=%h required addr=%0d data=%h",
                          j, wa_q[j], wd_q[j], exp_a_q[j], exp_d_q[j]);
      end
    end
    foreach (words[j]) words[j] = W'($urandom);
    clear_logs();
    do_op(1'b0, 6'd0, 7'd8, 16'h0, 100, -1, -1, 3, t0);
    ntests++;
    if ({bus.mem_we_o, bus.mem_addr_o, bus.mem_wdata_o, bus.busy_o, bus.done_o, bus.count_o, bus.wready_o} !== '0) begin
      nfail++;
      $display("FAIL rst_mid_outputs: we=%0b addr=%0d data=%h busy=%0b done=%0b count=%0d required all 0",
               bus.mem_we_o, bus.mem_addr_o, bus.mem_wdata_o, bus.busy_o, bus.done_o, bus.count_o);
    end
    ntests++;
    if (wa_q.size() != 3 || hs_q.size() != 3 || dn_c_q.size() != 0) begin
      nfail++; $display("FAIL rst_mid_partial: writes=%0d handshakes=%0d pulses=%0d required 3,3,0",
                        wa_q.size(), hs_q.size(), dn_c_q.size());
    end
    for (int j = 0; j < wa_q.size() && j < 3; j++) begin
      ntests++;
      if ({wa_q[j], wd_q[j]} !== {AW'(j), words[j]}) begin
        nfail++; $display("FAIL rst_mid_write%0d: addr=%0d data=%h required addr=%0d data=%h",
                          j, wa_q[j], wd_q[j], j, words[j]);
      end
    end
  endtask

  task automatic test_random;
    int t0, n;
    bit mode;
    logic [AW-1:0] a;
    logic [AW:0] l;
    logic [W-1:0] f;
    foreach (mem_dut[j]) begin mem_dut[j] = '0; mem_ref[j] = '0; end
    for (int it = 0; it < 8; it++) begin
      foreach (words[j]) words[j] = W'($urandom);
      mode = 1'($urandom);
      a = AW'($urandom);
      l = (AW+1)'($urandom_range(70));
      f = W'($urandom);
      n = (int'(l) > DEPTH) ? DEPTH : int'(l);
      clear_logs();
      model(mode, a, l, f, -1);
      do_op(mode, a, l, f, $urandom_range(40, 100), -1, -1, -1, t0);
      ntests++;
      if (wa_q.size() != n) begin nfail++; $display("FAIL rand%0d_nwrites: got %0d required %0d", it, wa_q.size(), n); end
      for (int j = 0; j < n && j < wa_q.size(); j++) begin
        ntests++;
        if ({wa_q[j], wd_q[j]} !== {exp_a_q[j], exp_d_q[j]}) begin
          nfail++; $display("FAIL rand%0d_write%0d: addr=%0d data=%h required addr=%0d data=%h",
                            it, j, wa_q[j], wd_q[j], exp_a_q[j], exp_d_q[j]);
        end
      end
      ntests++;
      if (dn_c_q.size() != 1 || dn_n_q[0] !== (AW+1)'(n) ||
          dn_c_q[0] != ((n > 0 && wc_q.size() > 0) ? wc_q[wc_q.size()-1] : t0 + 1)) begin
        nfail++; $display("FAIL rand%0d_done: pulses=%0d count=%0d required 1 pulse with last write, count %0d",
                          it, dn_c_q.size(), (dn_n_q.size() > 0) ? dn_n_q[0] : 0, n);
      end
`ifdef MEMW_CHECKSUM_EN
      ntests++;
      if (dn_s_q.size() != 1 || dn_s_q[0] !== exp_sum) begin
        nfail++; $display("FAIL rand%0d_checksum: got %h required %h", it, (dn_s_q.size() > 0) ? dn_s_q[0] : '0, exp_sum);
      end
`endif
    end
    for (int j = 0; j < DEPTH; j++) begin
      ntests++;
      if (mem_dut[j] !== mem_ref[j]) begin
        nfail++; $display("FAIL image[%0d]: got %h required %h", j, mem_dut[j], mem_ref[j]);
      end
    end
  endtask

`ifdef MEMW_CHECKSUM_EN
  task automatic test_checksum;
    int t0;
    words[0] = 16'hFFFF;
    words[1] = 16'h0002;
    clear_logs();
    do_op(1'b0, 6'd30, 7'd2, 16'h0, 100, -1, -1, -1, t0);
    ntests++;
    if (dn_s_q.size() != 1 || dn_s_q[0] !== 16'h0001) begin
      nfail++; $display("FAIL checksum_done: got %h required 0001", (dn_s_q.size() > 0) ? dn_s_q[0] : '0);
    end
    repeat (2) @(negedge clk);
    ntests++;
    if (bus.checksum_o !== 16'h0001) begin nfail++; $display("FAIL checksum_hold: got %h required 0001", bus.checksum_o); end
  endtask
`endif

  initial begin
    bus.start_i = 1'b0; bus.mode_i = 1'b0; bus.start_addr_i = '0; bus.len_i = '0; bus.fill_i = '0;
    bus.abort_i = 1'b0; bus.wvalid_i = 1'b0; bus.wdata_i = '0;
    foreach (mem_dut[j]) begin mem_dut[j] = '0; mem_ref[j] = '0; end
    test_reset();
    test_stream();
    test_backpressure();
    test_fill_wrap();
    test_zero_clamp();
    test_abort_reset();
    test_random();
`ifdef MEMW_CHECKSUM_EN
    test_checksum();
`endif
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation reached 500000 ns, required completion earlier");
    $fatal(1, "timeout");
  end
endmodule
